// File: rtl/mul_pkg.sv
// Shared definitions for the multiply-engine feeder: FSM states and default sizing.
package mul_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_A_HOLD  = 2;
  localparam int unsigned DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT,
    CLEAR,
    OUT
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_feeder_if.sv
// Operand, engine and result signals of the feeder; slave is the feeder side.
interface mul_feeder_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mul_start;
  logic [WIDTH-1:0] mul_bus;
  logic             mul_clr;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  modport master (
    output op_valid, op_a, op_b, mul_done, mul_prod, res_ready,
    input  op_ready, mul_start, mul_bus, mul_clr, res_valid, res_data, res_err
  );

  modport slave (
    input  op_valid, op_a, op_b, mul_done, mul_prod, res_ready,
    output op_ready, mul_start, mul_bus, mul_clr, res_valid, res_data, res_err
  );

endinterface

// File: rtl/mul_timeout_cntr.sv
// Cycle counter for the engine wait; expired is registered and true while count == TIMEOUT-1.
module mul_timeout_cntr
  import mul_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Flag is computed from the next count so it lines up with cnt_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      expired <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/mul_feeder.sv
// Sequences operand pairs onto a shared-bus multiply engine and returns its product,
// forcing an error result if the engine never signals done.
module mul_feeder
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned A_HOLD  = DEF_A_HOLD,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  mul_feeder_if.slave  bus
);

  localparam int unsigned HOLD_W = cnt_width(A_HOLD);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(A_HOLD - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  a_d;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  b_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;

  logic              op_ready_d;
  logic              mul_start_d;
  logic              mul_clr_d;
  logic [WIDTH-1:0]  mul_bus_d;
  logic              res_valid_d;
  logic [WIDTH-1:0]  res_data_d;
  logic              res_err_d;
  logic              wait_expired;

  mul_timeout_cntr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != WAIT),
    .enable  (state_q == WAIT),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      a_q     <= '0;
      b_q     <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hold_q  <= hold_d;
    end
  end

  // Next state plus next-cycle outputs, which are decoded from state_d and registered.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    hold_d     = hold_q;
    res_data_d = bus.res_data;
    res_err_d  = bus.res_err;

    unique case (state_q)
      INIT:   state_d = IDLE;
      IDLE: begin
        if (bus.op_valid) begin
          a_d = bus.op_a;
          b_d = bus.op_b;
          // A zero multiplier would never let the engine finish, so skip it entirely.
          if (bus.op_a == '0 || bus.op_b == '0) begin
            res_data_d = '0;
            res_err_d  = 1'b0;
            state_d    = OUT;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        hold_d  = '0;
        state_d = LOAD_A;
      end
      LOAD_A: begin
        if (hold_q == LAST_HOLD) begin
          state_d = LOAD_B;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      LOAD_B: state_d = WAIT;
      WAIT: begin
        if (bus.mul_done) begin
          res_data_d = bus.mul_prod;
          res_err_d  = 1'b0;
          state_d    = CLEAR;
        end else if (wait_expired) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR:  state_d = OUT;
      OUT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase

    op_ready_d  = (state_d == IDLE);
    mul_start_d = (state_d == START);
    mul_clr_d   = (state_d == INIT) || (state_d == CLEAR);
    res_valid_d = (state_d == OUT);

    unique case (state_d)
      START, LOAD_A: mul_bus_d = a_d;
      LOAD_B, WAIT:  mul_bus_d = b_d;
      default:       mul_bus_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.op_ready  <= 1'b0;
      bus.mul_start <= 1'b0;
      bus.mul_clr   <= 1'b1;
      bus.mul_bus   <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_err   <= 1'b0;
    end else begin
      bus.op_ready  <= op_ready_d;
      bus.mul_start <= mul_start_d;
      bus.mul_clr   <= mul_clr_d;
      bus.mul_bus   <= mul_bus_d;
      bus.res_valid <= res_valid_d;
      bus.res_data  <= res_data_d;
      bus.res_err   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_mul_feeder.sv
// Self-checking bench for mul_feeder: behavioural engine model plus result scoreboard.
module tb_mul_feeder;
  import mul_pkg::*;

  localparam int unsigned W       = DEF_WIDTH;
  localparam int          A_HOLD  = 2;
  localparam int          TIMEOUT = 1024;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mul_feeder_if #(.WIDTH(W)) bus ();

  mul_feeder #(
    .WIDTH   (W),
    .A_HOLD  (A_HOLD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  res_t exp_q[$];

  // Engine model configuration, written by the main sequence before each operation
  int           eng_delay = 4;
  bit           eng_never = 1'b0;
  logic [W-1:0] eng_prod  = '0;

  int ob_st_cnt, ob_st_cyc, ob_a_cnt, ob_b_cyc, ob_clr_cnt, ob_clr_cyc, ob_v_cyc;

  // Engine: done (sticky) eng_delay cycles after mul_start, cleared by mul_clr
  initial begin : engine
    int cnt;
    cnt = -1;
    bus.mul_done = 1'b0;
    bus.mul_prod = '0;
    forever begin
      @(negedge clk);
      if (bus.mul_clr) begin
        bus.mul_done = 1'b0;
        cnt = -1;
      end else if (bus.mul_start) begin
        if (!eng_never) cnt = eng_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mul_done = 1'b1;
          bus.mul_prod = eng_prod;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [W-1:0] d, input logic e);
    res_t r;
    r.data = d;
    r.err  = e;
    return r;
  endfunction

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
    while (!bus.op_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("op_ready_before_drive", 32'(bus.op_ready), 1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_valid = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the transfer edge; stops at the first res_valid
  task automatic observe(input int budget, input logic [W-1:0] a, input logic [W-1:0] b);
    ob_st_cnt = 0; ob_st_cyc = -1; ob_a_cnt = 0; ob_b_cyc = -1;
    ob_clr_cnt = 0; ob_clr_cyc = -1; ob_v_cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.mul_start) begin
        ob_st_cnt++;
        if (ob_st_cyc < 0) ob_st_cyc = n;
      end
      if (bus.mul_bus == a) ob_a_cnt++;
      if (bus.mul_bus == b && b != a && ob_b_cyc < 0) ob_b_cyc = n;
      if (bus.mul_clr) begin
        ob_clr_cnt++;
        if (ob_clr_cyc < 0) ob_clr_cyc = n;
      end
      if (bus.res_valid) begin
        ob_v_cyc = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag);
    res_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_sb: got a result, expected none queued", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(bus.res_valid), 1);
      chk({tag, "_data"},  32'(bus.res_data), 32'(e.data));
      chk({tag, "_err"},   32'(bus.res_err), 32'(e.err));
    end
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin : main
    int bad_ready, bad_hold, bad_valid;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_mul_clr",   32'(bus.mul_clr), 1);
    chk("rst_op_ready",  32'(bus.op_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_mul_start", 32'(bus.mul_start), 0);
    chk("rst_mul_bus",   32'(bus.mul_bus), 0);
    chk("rst_res_data",  32'(bus.res_data), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_op_ready", 32'(bus.op_ready), 1);
    chk("init_mul_clr",  32'(bus.mul_clr), 0);

    // Test 1: 3x5, done 4 cycles after start
    eng_delay = 4; eng_prod = W'(15);
    exp_q.push_back(mk(W'(15), 1'b0));
    drive_op(W'(3), W'(5));
    observe(100, W'(3), W'(5));
    chk("t1_start_cnt", 32'(ob_st_cnt), 1);
    chk("t1_start_cyc", 32'(ob_st_cyc), 1);
    chk("t1_a_cycles",  32'(ob_a_cnt), 32'(A_HOLD + 1));
    chk("t1_b_first",   32'(ob_b_cyc), 32'(A_HOLD + 2));
    chk("t1_clr_cnt",   32'(ob_clr_cnt), 1);
    chk("t1_clr_cyc",   32'(ob_clr_cyc), 32'(1 + eng_delay + 1));
    chk("t1_latency",   32'(ob_v_cyc), 32'(1 + eng_delay + 2));
    check_result("t1");
    accept();

    // Test 2: zero multiplier bypasses the engine
    exp_q.push_back(mk('0, 1'b0));
    drive_op(W'(7), W'(0));
    observe(20, W'(7), W'(0));
    chk("t2_valid_cyc", 32'(ob_v_cyc), 1);
    chk("t2_start_cnt", 32'(ob_st_cnt), 0);
    chk("t2_bus_a",     32'(ob_a_cnt), 0);
    check_result("t2");
    accept();

    // Test 3: engine never finishes
    eng_never = 1'b1;
    exp_q.push_back(mk('0, 1'b1));
    drive_op(W'(3), W'(5));
    observe(TIMEOUT + 100, W'(3), W'(5));
    chk("t3_clr_cnt",   32'(ob_clr_cnt), 1);
    chk("t3_clr_cyc",   32'(ob_clr_cyc), 32'(A_HOLD + TIMEOUT + 3));
    chk("t3_valid_cyc", 32'(ob_v_cyc), 32'(A_HOLD + TIMEOUT + 4));
    chk("t3_start_cnt", 32'(ob_st_cnt), 1);
    check_result("t3");
    accept();
    eng_never = 1'b0;

    // Test 4: consumer stalls while the next pair is already offered
    eng_delay = 4; eng_prod = W'(6);
    exp_q.push_back(mk(W'(6), 1'b0));
    drive_op(W'(2), W'(3));
    observe(100, W'(2), W'(3));
    chk("t4_valid_cyc", 32'(ob_v_cyc), 7);
    check_result("t4");
    bus.op_a = W'(4); bus.op_b = W'(4); bus.op_valid = 1'b1;
    bad_ready = 0; bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.op_ready !== 1'b0) bad_ready++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== W'(6) || bus.res_err !== 1'b0) bad_hold++;
    end
    chk("t4_op_ready_low", 32'(bad_ready), 0);
    chk("t4_result_held",  32'(bad_hold), 0);
    eng_prod = W'(16);
    exp_q.push_back(mk(W'(16), 1'b0));
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("t4_idle_ready", 32'(bus.op_ready), 1);
    chk("t4_idle_valid", 32'(bus.res_valid), 0);
    @(negedge clk);
    bus.op_valid = 1'b0;
    observe(100, W'(4), W'(4));
    chk("t4_next_start", 32'(ob_st_cyc), 1);
    chk("t4_next_valid", 32'(ob_v_cyc), 7);
    check_result("t4b");
    accept();

    // Test 5: reset asserted during WAIT
    eng_delay = 50; eng_prod = W'(99);
    drive_op(W'(3), W'(5));
    repeat (A_HOLD + 3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_mul_clr",   32'(bus.mul_clr), 1);
    chk("t5_op_ready",  32'(bus.op_ready), 0);
    chk("t5_res_valid", 32'(bus.res_valid), 0);
    chk("t5_mul_bus",   32'(bus.mul_bus), 0);
    chk("t5_mul_start", 32'(bus.mul_start), 0);
    chk("t5_res_data",  32'(bus.res_data), 0);
    chk("t5_res_err",   32'(bus.res_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t5_init_ready", 32'(bus.op_ready), 0);
    @(negedge clk);
    chk("t5_ready_after", 32'(bus.op_ready), 1);
    bad_valid = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.mul_start !== 1'b0) bad_valid++;
    end
    chk("t5_no_result", 32'(bad_valid), 0);

    // Test 6: product wraps modulo 2^16
    eng_delay = 4; eng_prod = W'(16'h5F90);
    exp_q.push_back(mk(W'(16'h5F90), 1'b0));
    drive_op(W'(300), W'(300));
    observe(100, W'(300), W'(300));
    chk("t6_valid_cyc", 32'(ob_v_cyc), 7);
    check_result("t6");
    accept();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_feeder.md
MUL_FEEDER -- requirements
Module: mul_feeder

Interface
REQ-001 Parameter WIDTH, default 16: width of operands, bus, product and result.
REQ-002 Parameter A_HOLD, default 2: number of cycles operand A stays on mul_bus after the start cycle, minimum 1.
REQ-003 Parameter TIMEOUT, default 1024: maximum number of WAIT cycles allowed before an error result is forced.
REQ-004 The block SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-005 Ports SHALL be, as name / direction / width / meaning:
- clk  in  1  clock
- rst  in  1  async active-high reset
- op_valid  in  1  operand pair offered
- op_ready  out  1  feeder accepts a pair
- op_a  in  WIDTH  multiplicand
- op_b  in  WIDTH  multiplier (repeat count)
- mul_start  out  1  start pulse to multiply engine
- mul_bus  out  WIDTH  shared engine data_in bus
- mul_clr  out  1  returns engine to idle
- mul_done  in  1  engine done, sticky until mul_clr
- mul_prod  in  WIDTH  engine product register
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  product, modulo 2^WIDTH
- res_err  out  1  result forced by timeout

Function
REQ-006 The FSM SHALL have the states INIT, IDLE, START, LOAD_A, LOAD_B, WAIT, CLEAR and OUT.
REQ-007 op_ready SHALL be 1 only in IDLE; a transfer occurs when op_valid=1 and op_ready=1 at a rising edge, and op_a/op_b are then latched.
REQ-008 On a transfer with op_a==0 or op_b==0: next state OUT with res_data=0 and res_err=0; the engine is not started (B=0 would never terminate).
REQ-009 On any other transfer: next state START.
REQ-010 START lasts 1 cycle with mul_start=1 and mul_bus=A, then goes to LOAD_A.
REQ-011 LOAD_A holds mul_bus=A for A_HOLD cycles, then goes to LOAD_B.
REQ-012 LOAD_B lasts 1 cycle with mul_bus=B, then goes to WAIT.
REQ-013 WAIT holds mul_bus=B and counts cycles; when mul_done=1 is sampled it captures mul_prod into res_data, sets res_err=0 and goes to CLEAR.
REQ-014 If the WAIT counter reaches TIMEOUT-1 without mul_done, the block SHALL set res_data=0 and res_err=1 and go to CLEAR; if done and timeout occur in the same cycle, done wins.
REQ-015 CLEAR lasts 1 cycle with mul_clr=1, then goes to OUT.
REQ-016 OUT holds res_valid=1 with res_data and res_err stable until res_ready=1, then goes to IDLE.
REQ-017 Result latency SHALL be 2 cycles from the cycle in which mul_done is sampled to res_valid=1.
REQ-018 mul_bus SHALL be 0 in INIT, IDLE, CLEAR and OUT.
REQ-019 mul_start and mul_clr SHALL each be 1 only in the states named above.
REQ-020 The timeout counter SHALL be ceil(log2(TIMEOUT)) bits wide and clear on entry to WAIT.
REQ-021 No arithmetic is performed on operands or product; the width is fixed at WIDTH.

Reset
REQ-022 While rst=1: state=INIT, mul_clr=1, and all other outputs 0 (res_data=0, res_err=0, op_ready=0).
REQ-023 INIT lasts 1 cycle after rst is released, then goes to IDLE, so the engine is always cleared.
REQ-024 Reset mid-operation SHALL abandon the operation with no result emitted.

Structure
REQ-025 The FSM state enum and the default WIDTH, A_HOLD and TIMEOUT values SHALL live in the shared package mul_pkg.
REQ-026 The timeout counter SHALL be one natural sub-module, mul_timeout_cntr (clear, enable, expired).

Verification
REQ-027 Test 1 SHALL check this sequence:
- stimulus: op 3x5; model done 4 cycles after mul_start; mul_prod=15
- required: mul_start for 1 cycle; mul_bus=3 for 3 cycles, then 5; mul_clr pulse; res_data=15, res_err=0 two cycles after done.
REQ-028 Test 2 SHALL check this sequence:
- stimulus: op_b=0, op_a=7
- required: res_valid the next cycle with res_data=0; mul_start never 1.
REQ-029 Test 3 SHALL check this sequence:
- stimulus: mul_done held 0
- required: after 1024 WAIT cycles, res_err=1, res_data=0, mul_clr pulse.
REQ-030 Test 4 SHALL check this sequence:
- stimulus: res_ready=0 for 10 cycles, with op_valid held 1
- required: op_ready=0 and the result held stable; on res_ready=1, IDLE and acceptance of the next pair.
REQ-031 Test 5 SHALL check this sequence:
- stimulus: rst asserted during WAIT
- required: outputs immediately at reset values with mul_clr=1; 1 cycle after release op_ready=1; no res_valid.
REQ-032 Test 6 SHALL check this sequence:
- stimulus: 300x300, model mul_prod=0x5F90
- required: res_data=0x5F90 (modulo 2^16), res_err=0.
